// File: rtl/picorv32_wb_master_pkg.sv
// picorv32_wb_master_pkg: shared Wishbone constants and bridge FSM state type
package picorv32_wb_master_pkg;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUS     = 2'd1,
      BACKOFF = 2'd2,
      RESP    = 2'd3
   } state_e;
   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/picorv32_wb_master.sv
// picorv32_wb_master: picorv32 native memory port to Wishbone B4 classic master
// Ports: clk/resetn (async active-low); mem_* CPU request/response; wbm_* Wishbone
// master; bus_err_o pulses with mem_ready on a failed transfer; err_addr_o and
// err_instr_o hold the address and fetch flag of the last failed transfer.
module picorv32_wb_master
   import picorv32_wb_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned RTY_MAX        = 3,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,
   output logic        bus_err_o,
   output logic [31:0] err_addr_o,
   output logic        err_instr_o
);
   localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int RW = RTY_MAX > 0 ? $clog2(RTY_MAX + 1) : 1;
   state_e        state_q;
   logic [31:0]   addr_q, dat_q, rdata_q, err_addr_q;
   logic [3:0]    sel_q;
   logic          we_q, instr_q, cyc_q, fail_q, err_instr_q;
   logic [TW-1:0] to_cnt_q;
   logic [RW-1:0] rty_cnt_q;
   logic          to_hit, rty_hit, fail_now;
   assign to_hit  = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
   assign rty_hit = rty_cnt_q == RW'(RTY_MAX);
   // err beats ack, ack beats rty, any termination beats the watchdog
   assign fail_now = wbm_err_i | (~wbm_ack_i & wbm_rty_i & rty_hit) |
                     (~wbm_ack_i & ~wbm_rty_i & to_hit);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         instr_q     <= 1'b0;
         cyc_q       <= 1'b0;
         fail_q      <= 1'b0;
         rdata_q     <= '0;
         err_addr_q  <= '0;
         err_instr_q <= 1'b0;
         to_cnt_q    <= '0;
         rty_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (mem_valid) begin
               addr_q    <= mem_addr;
               dat_q     <= mem_wdata;
               we_q      <= |mem_wstrb;
               sel_q     <= |mem_wstrb ? mem_wstrb : 4'hF;
               instr_q   <= mem_instr;
               cyc_q     <= 1'b1;
               fail_q    <= 1'b0;
               to_cnt_q  <= '0;
               rty_cnt_q <= '0;
               state_q   <= BUS;
            end
            BUS: if (fail_now) begin
               cyc_q       <= 1'b0;
               rdata_q     <= ERR_RDATA;
               fail_q      <= 1'b1;
               err_addr_q  <= addr_q;
               err_instr_q <= instr_q;
               state_q     <= RESP;
            end else if (wbm_ack_i) begin
               cyc_q   <= 1'b0;
               rdata_q <= we_q ? rdata_q : wbm_dat_i;
               state_q <= RESP;
            end else if (wbm_rty_i) begin
               cyc_q     <= 1'b0;
               rty_cnt_q <= rty_cnt_q + RW'(1);
               state_q   <= BACKOFF;
            end else begin
               to_cnt_q <= to_cnt_q + TW'(1);
            end
            BACKOFF: begin
               to_cnt_q <= '0;
               cyc_q    <= 1'b1;
               state_q  <= BUS;
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   // a CPU that has withdrawn its request gets no completion pulse
   assign mem_ready   = (state_q == RESP) & mem_valid;
   assign bus_err_o   = mem_ready & fail_q;
   assign mem_rdata   = rdata_q;
   assign wbm_adr_o   = word_addr(addr_q);
   assign wbm_dat_o   = dat_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_we_o    = we_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_cti_o   = CTI_CLASSIC;
   assign wbm_bte_o   = BTE_LINEAR;
   assign err_addr_o  = err_addr_q;
   assign err_instr_o = err_instr_q;
endmodule
